max_sel: RTL and testbench

- Two-input maximum selector for the arbiter's comparator stage.
- Compares two WIDTH-bit priority/request values and returns the larger one.
- Also returns a select flag that identifies which input won, so downstream arbitration logic can steer grants.
- Outputs are registered: one clock of latency, with a valid qualifier.

---
 rtl/max_sel.sv | 58 +++++
 tb/tb_max_sel.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/max_sel.sv
// Registered two-input maximum selector: picks the larger of in1/in2, reports
// which input won and whether they were equal, one cycle after sampling.
module max_sel #(
    parameter int WIDTH  = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             sel,
    output logic             eq,
    output logic             out_valid
);

    logic             w_gt_signed;
    logic             w_gt_unsigned;
    logic             w_gt;
    logic             w_eq;
    logic [WIDTH-1:0] w_max;

    logic [WIDTH-1:0] r_out;
    logic             r_sel;
    logic             r_eq;
    logic             r_out_valid;

    // Strict greater-than keeps ties on in1 (lower index wins).
    assign w_gt_signed   = $signed(in2) > $signed(in1);
    assign w_gt_unsigned = in2 > in1;
    assign w_gt          = SIGNED ? w_gt_signed : w_gt_unsigned;
    assign w_eq          = (in1 == in2);
    assign w_max         = w_gt ? in2 : in1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_sel       <= 1'b0;
            r_eq        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            // Idle cycles leave the last result in place, whatever the inputs carry.
            if (in_valid) begin
                r_out <= w_max;
                r_sel <= w_gt;
                r_eq  <= w_eq;
            end
        end
    end

    assign out       = r_out;
    assign sel       = r_sel;
    assign eq        = r_eq;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_max_sel.sv
// Bench for max_sel: unsigned and signed WIDTH=2 instances share one stimulus
// stream and are checked against an integer-arithmetic reference model.
module tb_max_sel;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in1;
    logic [1:0] in2;

    logic [1:0] u_out;
    logic       u_sel, u_eq, u_vld;
    logic [1:0] s_out;
    logic       s_sel, s_eq, s_vld;

    int checks = 0;
    int errors = 0;

    // Expected entry: {valid, u_out, u_sel, u_eq, s_out, s_sel, s_eq}
    logic [8:0] exp_q[$];

    // Reference state: last accepted result per mode.
    logic [1:0] m_u_out, m_s_out;
    logic       m_u_sel, m_u_eq, m_s_sel, m_s_eq;

    max_sel #(.WIDTH(2), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
        .out(u_out), .sel(u_sel), .eq(u_eq), .out_valid(u_vld)
    );

    max_sel #(.WIDTH(2), .SIGNED(1'b1)) s_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
        .out(s_out), .sel(s_sel), .eq(s_eq), .out_valid(s_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_int(input logic [1:0] v, input bit signed_mode);
        if (signed_mode && v[1]) return int'(v) - 4;
        return int'(v);
    endfunction

    task automatic model_reset();
        m_u_out = 2'd0; m_u_sel = 1'b0; m_u_eq = 1'b0;
        m_s_out = 2'd0; m_s_sel = 1'b0; m_s_eq = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_u_out"}, 32'(u_out), 32'd0);
        check({tag, "_u_sel"}, 32'(u_sel), 32'd0);
        check({tag, "_u_eq"},  32'(u_eq),  32'd0);
        check({tag, "_u_vld"}, 32'(u_vld), 32'd0);
        check({tag, "_s_out"}, 32'(s_out), 32'd0);
        check({tag, "_s_sel"}, 32'(s_sel), 32'd0);
        check({tag, "_s_eq"},  32'(s_eq),  32'd0);
        check({tag, "_s_vld"}, 32'(s_vld), 32'd0);
    endtask

    // Apply inputs and record what the next rising edge should produce.
    task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b);
        int ua, ub, sa, sb;
        in_valid = v; in1 = a; in2 = b;
        if (v) begin
            ua = to_int(a, 1'b0); ub = to_int(b, 1'b0);
            sa = to_int(a, 1'b1); sb = to_int(b, 1'b1);
            m_u_sel = (ub > ua); m_u_out = m_u_sel ? b : a; m_u_eq = (ua == ub);
            m_s_sel = (sb > sa); m_s_out = m_s_sel ? b : a; m_s_eq = (sa == sb);
        end
        exp_q.push_back({v, m_u_out, m_u_sel, m_u_eq, m_s_out, m_s_sel, m_s_eq});
    endtask

    task automatic compare_pending();
        logic [8:0] e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("u_vld", 32'(u_vld), 32'(e[8]));
        check("u_out", 32'(u_out), 32'(e[7:6]));
        check("u_sel", 32'(u_sel), 32'(e[5]));
        check("u_eq",  32'(u_eq),  32'(e[4]));
        check("s_vld", 32'(s_vld), 32'(e[8]));
        check("s_out", 32'(s_out), 32'(e[3:2]));
        check("s_sel", 32'(s_sel), 32'(e[1]));
        check("s_eq",  32'(s_eq),  32'(e[0]));
    endtask

    task automatic step(input logic v, input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        compare_pending();
        drive(v, a, b);
    endtask

    initial begin
        logic [1:0] da[6];
        logic [1:0] db[6];
        da = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
        db = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01};

        model_reset();
        rst_n = 1'b0; in_valid = 1'b1; in1 = 2'd2; in2 = 2'd1;
        repeat (3) begin
            @(negedge clk);
            check_reset_state("rst_hold");
        end

        // Release between edges; the very next edge accepts a sample.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 2'd1);

        // Exhaustive pair sweep, one per cycle.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                step(1'b1, 2'(a), 2'(b));

        // Hold: result persists while idle regardless of input values.
        step(1'b1, 2'd1, 2'd3);
        repeat (4) step(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

        // Directed signed-sensitive pairs.
        for (int i = 0; i < 6; i++) step(1'b1, da[i], db[i]);

        // Throughput: 8 back-to-back valid samples.
        repeat (8) step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

        // Random mix of valid and idle cycles.
        repeat (40) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

        // Mid-stream asynchronous reset: check the landed result, then clear between edges.
        step(1'b1, 2'd3, 2'd0);
        @(posedge clk);
        #1 compare_pending();
        in_valid = 1'b1; in1 = 2'd2; in2 = 2'd3;
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_async");
        repeat (2) begin
            @(negedge clk);
            check_reset_state("rst_mid");
        end
        exp_q.delete();
        model_reset();

        // Release with in_valid low: no pulse, cleared values remain.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd3, 2'd1);
        step(1'b1, 2'd1, 2'd2);
        step(1'b0, 2'd0, 2'd0);
        step(1'b0, 2'd0, 2'd0);
        @(negedge clk);
        compare_pending();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
